// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - register pipeline with valid/ready flow control, bubble collapse and flush
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][WIDTH-1:0]  d_q, d_d;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic [DEPTH:0]               rdy;
    logic [DEPTH-1:0]             load;
    logic                         in_ready_c;

    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        // A stage is ready when empty or when the stage after it is ready.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v_q[i] || rdy[i+1];
        end
        in_ready_c = rdy[0] && !flush;

        load    = '0;
        load[0] = in_valid && in_ready_c;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = v_q[i-1] && rdy[i] && !flush;
        end

        v_d = v_q;
        d_d = d_q;
        if (load[0]) begin
            d_d[0] = in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load[i]) begin
                d_d[i] = d_q[i-1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (load[i]) begin
                v_d[i] = 1'b1;
            end else if (v_q[i] && rdy[i+1]) begin
                v_d[i] = 1'b0;
            end
        end

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            d_q   <= {DEPTH{RESET_VAL}};
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = v_q[DEPTH-1] && !flush;
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule
